// File: rtl/rd_req_arb_mux_if.sv
// rd_req_arb_mux_if
// Bundles the source-side and memory-side read request/response channels
// of rd_req_arb_mux into one interface.
//   src_rd_req_*  : per-source request valid/address/ready
//   src_rd_resp_* : per-source response valid/ready, broadcast data
//   dst_rd_req_*  : single memory read request port
//   dst_rd_resp_* : single memory read response port
// Modports:
//   master : the multiplexer itself
//   slave  : the surrounding sources and memory (environment view)
interface rd_req_arb_mux_if #(
  parameter int NUM_SRCS = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 64
);
  logic [NUM_SRCS-1:0]        src_rd_req_val;
  logic [NUM_SRCS*ADDR_W-1:0] src_rd_req_addr;
  logic [NUM_SRCS-1:0]        src_rd_req_rdy;
  logic [NUM_SRCS-1:0]        src_rd_resp_val;
  logic [DATA_W-1:0]          src_rd_resp_data;
  logic [NUM_SRCS-1:0]        src_rd_resp_rdy;
  logic                       dst_rd_req_val;
  logic [ADDR_W-1:0]          dst_rd_req_addr;
  logic                       dst_rd_req_rdy;
  logic                       dst_rd_resp_val;
  logic [DATA_W-1:0]          dst_rd_resp_data;
  logic                       dst_rd_resp_rdy;

  modport master (
    input  src_rd_req_val, src_rd_req_addr, src_rd_resp_rdy,
    input  dst_rd_req_rdy, dst_rd_resp_val, dst_rd_resp_data,
    output src_rd_req_rdy, src_rd_resp_val, src_rd_resp_data,
    output dst_rd_req_val, dst_rd_req_addr, dst_rd_resp_rdy
  );

  modport slave (
    output src_rd_req_val, src_rd_req_addr, src_rd_resp_rdy,
    output dst_rd_req_rdy, dst_rd_resp_val, dst_rd_resp_data,
    input  src_rd_req_rdy, src_rd_resp_val, src_rd_resp_data,
    input  dst_rd_req_val, dst_rd_req_addr, dst_rd_resp_rdy
  );
endinterface

// File: rtl/rd_req_arb_mux.sv
// rd_req_arb_mux
// N-source read-port multiplexer for a backpressured synchronous memory.
// One request per cycle is granted (fixed priority or round-robin) and
// forwarded to the memory with zero added latency. The granted source index
// is queued in a tag FIFO so each in-order memory response is routed back to
// the source that issued it.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (master)     : source and memory request/response channels
//   outstanding_cnt  : number of reads currently in flight
//   resp_err         : sticky, set when a response arrives with nothing in flight
module rd_req_arb_mux #(
  parameter int NUM_SRCS        = 2,
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  rd_req_arb_mux_if.master                     bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                                 resp_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int IDX_W = $clog2(NUM_SRCS);

  logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [IDX_W-1:0] head;
  logic             tag_full;
  logic             tag_empty;
  logic             issue;
  logic             pop;

  // Source index base+k folded back into 0..NUM_SRCS-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NUM_SRCS) s = s - NUM_SRCS;
    return IDX_W'(s);
  endfunction

  assign tag_full  = (outstanding_cnt == CNT_W'(MAX_OUTSTANDING));
  assign tag_empty = (outstanding_cnt == '0);
  assign head      = tag_mem[rd_ptr];

  // Loops run from the far end toward the winner so the highest-priority
  // candidate is the last one written.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_SRCS - 1; i >= 0; i--) begin
        if (bus.src_rd_req_val[i]) begin
          gnt_idx = IDX_W'(i);
          gnt_any = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_SRCS - 1; k >= 0; k--) begin
        if (bus.src_rd_req_val[wrap_idx(int'(rr_ptr), k)]) begin
          gnt_idx = wrap_idx(int'(rr_ptr), k);
          gnt_any = 1'b1;
        end
      end
    end
  end

  assign bus.dst_rd_req_val  = gnt_any && !tag_full;
  assign bus.dst_rd_req_addr = gnt_any ? bus.src_rd_req_addr[gnt_idx*ADDR_W +: ADDR_W]
                                       : '0;
  assign bus.src_rd_req_rdy  = (gnt_any && bus.dst_rd_req_rdy && !tag_full)
                               ? (NUM_SRCS'(1) << gnt_idx) : '0;
  assign issue = bus.dst_rd_req_val && bus.dst_rd_req_rdy;

  // With nothing in flight the response is accepted and dropped, so the
  // memory port can never deadlock on a stray response.
  assign bus.src_rd_resp_val  = (bus.dst_rd_resp_val && !tag_empty)
                                ? (NUM_SRCS'(1) << head) : '0;
  assign bus.src_rd_resp_data = bus.dst_rd_resp_data;
  assign bus.dst_rd_resp_rdy  = tag_empty ? 1'b1 : bus.src_rd_resp_rdy[head];
  assign pop = bus.dst_rd_resp_val && bus.dst_rd_resp_rdy && !tag_empty;

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rr_ptr          <= '0;
      outstanding_cnt <= '0;
      resp_err        <= 1'b0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({issue, pop})
        2'b10:   outstanding_cnt <= outstanding_cnt + CNT_W'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - CNT_W'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase
      if (bus.dst_rd_resp_val && tag_empty) resp_err <= 1'b1;
      if (ARB_MODE == 1 && issue) rr_ptr <= wrap_idx(int'(gnt_idx), 1);
    end
  end

endmodule

// File: tb/tb_rd_req_arb_mux.sv
// tb_rd_req_arb_mux
// Self-checking bench for rd_req_arb_mux. Instance dut_a (2 sources, fixed
// priority) is checked against a scoreboard fed when requests are issued and
// drained when responses reach the sources; instance dut_b (3 sources,
// round-robin) is checked for grant order.
module tb_rd_req_arb_mux;

  typedef struct {
    int          src;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [2:0] cnt_a;
  logic [2:0] cnt_b;
  logic       err_a;
  logic       err_b;

  int checks;
  int errors;

  exp_t       exp_q[$];
  logic [7:0] mem_q_a[$];
  int         mem_b_cnt;
  logic       stall_a;
  logic       stray_a;

  rd_req_arb_mux_if #(.NUM_SRCS(2), .ADDR_W(8), .DATA_W(64)) bus_a ();
  rd_req_arb_mux_if #(.NUM_SRCS(3), .ADDR_W(8), .DATA_W(64)) bus_b ();

  rd_req_arb_mux #(
    .NUM_SRCS(2), .ADDR_W(8), .DATA_W(64), .MAX_OUTSTANDING(4), .ARB_MODE(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .outstanding_cnt(cnt_a), .resp_err(err_a)
  );

  rd_req_arb_mux #(
    .NUM_SRCS(3), .ADDR_W(8), .DATA_W(64), .MAX_OUTSTANDING(4), .ARB_MODE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .outstanding_cnt(cnt_b), .resp_err(err_b)
  );

  always #5 clk = ~clk;

  // Memory contents as seen by both the memory model and the scoreboard.
  function automatic logic [63:0] mem_fn(input logic [7:0] addr);
    if (addr == 8'h2A) return 64'hDEAD;
    return 64'hC0DE_0000_0000_0000 | {56'h0, addr};
  endfunction

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] val, input logic [7:0] a0,
                               input logic [7:0] a1);
    bus_a.src_rd_req_val  = val;
    bus_a.src_rd_req_addr = {a1, a0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) next_cycle();
    checkOutput("drain_pending", exp_q.size(), 0);
    checkOutput("drain_cnt", cnt_a, 0);
  endtask

  // Observe transfers while all signals are settled, ahead of the edge that
  // performs them: feed the scoreboard and the memory model, check returns.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.dst_rd_resp_val && bus_a.dst_rd_resp_rdy && !stray_a &&
          mem_q_a.size() > 0)
        void'(mem_q_a.pop_front());
      if (bus_a.dst_rd_req_val && bus_a.dst_rd_req_rdy) begin
        int g;
        logic [7:0] a;
        g = bus_a.src_rd_req_val[0] ? 0 : 1;
        a = bus_a.src_rd_req_addr[g*8 +: 8];
        checkOutput("req_gnt", bus_a.src_rd_req_rdy, oh(g));
        checkOutput("req_addr", bus_a.dst_rd_req_addr, a);
        exp_q.push_back('{g, mem_fn(a)});
        mem_q_a.push_back(bus_a.dst_rd_req_addr);
      end
      for (int i = 0; i < 2; i++) begin
        if (bus_a.src_rd_resp_val[i] && bus_a.src_rd_resp_rdy[i]) begin
          if (exp_q.size() == 0) begin
            checkOutput("resp_unexpected", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("resp_src", i, e.src);
            checkOutput("resp_data", bus_a.src_rd_resp_data, e.data);
          end
        end
      end
      if (bus_b.dst_rd_resp_val && bus_b.dst_rd_resp_rdy && mem_b_cnt > 0)
        mem_b_cnt--;
      if (bus_b.dst_rd_req_val && bus_b.dst_rd_req_rdy) mem_b_cnt++;
    end
  end

  // Memories answer one cycle after issue, in order, unless stalled.
  always @(posedge clk) begin
    #2;
    bus_a.dst_rd_resp_val  = stray_a || (!stall_a && mem_q_a.size() > 0);
    bus_a.dst_rd_resp_data = (mem_q_a.size() > 0 && !stray_a) ? mem_fn(mem_q_a[0]) : 64'h0;
    bus_b.dst_rd_resp_val  = (mem_b_cnt > 0);
    bus_b.dst_rd_resp_data = 64'(mem_b_cnt);
  end

  initial begin
    int seq[6];
    seq = '{0, 1, 2, 0, 1, 2};
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    stall_a = 1'b0;
    stray_a = 1'b0;
    mem_b_cnt = 0;
    applyStimulus(2'b00, 8'h00, 8'h00);
    bus_a.src_rd_resp_rdy  = 2'b11;
    bus_a.dst_rd_req_rdy   = 1'b1;
    bus_a.dst_rd_resp_val  = 1'b0;
    bus_a.dst_rd_resp_data = 64'h0;
    bus_b.src_rd_req_val   = 3'b000;
    bus_b.src_rd_req_addr  = {8'h03, 8'h02, 8'h01};
    bus_b.src_rd_resp_rdy  = 3'b111;
    bus_b.dst_rd_req_rdy   = 1'b1;
    bus_b.dst_rd_resp_val  = 1'b0;
    bus_b.dst_rd_resp_data = 64'h0;

    $display("[TB] reset state");
    repeat (2) next_cycle();
    checkOutput("rst_cnt", cnt_a, 0);
    checkOutput("rst_err", err_a, 0);
    checkOutput("rst_req_val", bus_a.dst_rd_req_val, 0);
    checkOutput("rst_req_rdy", bus_a.src_rd_req_rdy, 0);
    checkOutput("rst_resp_val", bus_a.src_rd_resp_val, 0);
    checkOutput("rst_resp_rdy", bus_a.dst_rd_resp_rdy, 1);
    rst_n = 1'b1;
    next_cycle();

    $display("[TB] single read");
    applyStimulus(2'b10, 8'h00, 8'h2A);
    @(negedge clk);
    checkOutput("t1_addr", bus_a.dst_rd_req_addr, 8'h2A);
    checkOutput("t1_cnt0", cnt_a, 0);
    next_cycle();
    applyStimulus(2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t1_cnt1", cnt_a, 1);
    checkOutput("t1_resp_val", bus_a.src_rd_resp_val, 2'b10);
    checkOutput("t1_data", bus_a.src_rd_resp_data, 64'hDEAD);
    next_cycle();
    @(negedge clk);
    checkOutput("t1_cnt2", cnt_a, 0);
    next_cycle();

    $display("[TB] fixed-priority contention");
    applyStimulus(2'b11, 8'h05, 8'h06);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t2_gnt", bus_a.src_rd_req_rdy, 2'b01);
      next_cycle();
    end
    applyStimulus(2'b00, 8'h00, 8'h00);
    drain(20);

    $display("[TB] full tag fifo");
    stall_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 8'h10 + 8'(k), 8'h00);
      @(negedge clk);
      checkOutput("t4_rdy", bus_a.src_rd_req_rdy, 2'b01);
      next_cycle();
    end
    applyStimulus(2'b01, 8'h20, 8'h00);
    @(negedge clk);
    checkOutput("t4_full_rdy", bus_a.src_rd_req_rdy, 2'b00);
    checkOutput("t4_full_cnt", cnt_a, 4);
    checkOutput("t4_full_val", bus_a.dst_rd_req_val, 0);
    next_cycle();
    stall_a = 1'b0;
    @(negedge clk);
    checkOutput("t4_pop_resp", bus_a.src_rd_resp_val, 2'b01);
    checkOutput("t4_pop_rdy", bus_a.src_rd_req_rdy, 2'b00);
    next_cycle();
    @(negedge clk);
    checkOutput("t4_next_rdy", bus_a.src_rd_req_rdy, 2'b01);
    checkOutput("t4_cnt3", cnt_a, 3);
    next_cycle();
    applyStimulus(2'b00, 8'h00, 8'h00);
    drain(20);

    $display("[TB] response backpressure");
    bus_a.src_rd_resp_rdy = 2'b10;
    applyStimulus(2'b01, 8'h31, 8'h00);
    next_cycle();
    applyStimulus(2'b10, 8'h00, 8'h32);
    @(negedge clk);
    checkOutput("t5_bp0", bus_a.dst_rd_resp_rdy, 0);
    next_cycle();
    applyStimulus(2'b01, 8'h33, 8'h00);
    @(negedge clk);
    checkOutput("t5_bp1", bus_a.dst_rd_resp_rdy, 0);
    next_cycle();
    applyStimulus(2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t5_bp2", bus_a.dst_rd_resp_rdy, 0);
    checkOutput("t5_cnt", cnt_a, 3);
    next_cycle();
    bus_a.src_rd_resp_rdy = 2'b11;
    drain(20);

    $display("[TB] stray response and reset");
    stray_a = 1'b1;
    @(negedge clk);
    checkOutput("t6_stray_rdy", bus_a.dst_rd_resp_rdy, 1);
    checkOutput("t6_stray_val", bus_a.src_rd_resp_val, 0);
    next_cycle();
    stray_a = 1'b0;
    @(negedge clk);
    checkOutput("t6_err", err_a, 1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checkOutput("t6_sticky", err_a, 1);
    next_cycle();
    stall_a = 1'b1;
    applyStimulus(2'b01, 8'h40, 8'h00);
    next_cycle();
    applyStimulus(2'b01, 8'h41, 8'h00);
    next_cycle();
    applyStimulus(2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t6_inflight", cnt_a, 2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_cnt", cnt_a, 0);
    checkOutput("t6_rst_err", err_a, 0);
    checkOutput("t6_rst_resp_val", bus_a.src_rd_resp_val, 0);
    checkOutput("t6_rst_resp_rdy", bus_a.dst_rd_resp_rdy, 1);
    exp_q.delete();
    mem_q_a.delete();
    mem_b_cnt = 0;
    next_cycle();
    rst_n = 1'b1;
    stall_a = 1'b0;
    applyStimulus(2'b01, 8'h2A, 8'h00);
    @(negedge clk);
    checkOutput("t6_post_cnt0", cnt_a, 0);
    next_cycle();
    applyStimulus(2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t6_post_resp", bus_a.src_rd_resp_val, 2'b01);
    checkOutput("t6_post_data", bus_a.src_rd_resp_data, 64'hDEAD);
    checkOutput("t6_post_err", err_a, 0);
    next_cycle();
    drain(10);

    $display("[TB] round-robin fairness");
    bus_b.src_rd_req_val = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("t3_gnt", bus_b.src_rd_req_rdy, oh(seq[k]));
      if (k > 0) begin
        checkOutput("t3_resp", bus_b.src_rd_resp_val, oh(seq[k-1]));
        checkOutput("t3_cnt", cnt_b, 1);
      end
      next_cycle();
    end
    bus_b.src_rd_req_val = 3'b000;
    repeat (3) next_cycle();
    checkOutput("t3_drain_cnt", cnt_b, 0);
    checkOutput("t3_err", err_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/rd_req_arb_mux.md
# rd_req_arb_mux

Parametrised N-source read-port multiplexer for backpressured synchronous state memories (rx/tx state, tuple tables) in the TCP TX/RX pipelines. It arbitrates up to NUM_SRCS requesters onto one memory read port using fixed-priority or round-robin arbitration. Multiple reads may be in flight at once. A tag FIFO of granted source indices routes each memory response back, in order, to the source that issued the request.

## Interface
- NUM_SRCS, 2: number of requesting sources; legal range 2..8.
- ADDR_W, 8: read address width.
- DATA_W, 64: read data width.
- MAX_OUTSTANDING, 4: tag FIFO depth, i.e. the maximum number of in-flight reads; power of 2, minimum 2.
- ARB_MODE, 0: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_rd_req_val  in  NUM_SRCS  per-source request valid.
- src_rd_req_addr  in  NUM_SRCS*ADDR_W  per-source address; source i occupies bits [i*ADDR_W +: ADDR_W].
- src_rd_req_rdy  out  NUM_SRCS  per-source request ready; one-hot or zero.
- src_rd_resp_val  out  NUM_SRCS  per-source response valid; one-hot or zero.
- src_rd_resp_data  out  DATA_W  response data, broadcast to all sources; equals dst_rd_resp_data.
- src_rd_resp_rdy  in  NUM_SRCS  per-source response ready.
- dst_rd_req_val  out  1  memory request valid.
- dst_rd_req_addr  out  ADDR_W  memory request address.
- dst_rd_req_rdy  in  1  memory request ready.
- dst_rd_resp_val  in  1  memory response valid.
- dst_rd_resp_data  in  DATA_W  memory response data.
- dst_rd_resp_rdy  out  1  memory response ready.
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  number of reads currently in flight.
- resp_err  out  1  sticky flag: a response arrived while no read was outstanding.

## Operation
- Grant computation (combinational):
  - gnt is one-hot over the sources with valid requests.
  - ARB_MODE=0: the lowest valid index wins.
  - ARB_MODE=1: search starts at rr_ptr and wraps; the first valid index wins.
- Request path:
  - dst_rd_req_val = |src_rd_req_val && !tag_full.
  - dst_rd_req_addr = address of the granted source; it is 0 when no source is valid.
  - src_rd_req_rdy[i] = gnt[i] && dst_rd_req_rdy && !tag_full.
- Issue: on dst_rd_req_val && dst_rd_req_rdy, push the granted index into the tag FIFO.
- Round-robin pointer (ARB_MODE=1 only):
  - On each issue, rr_ptr <= (granted index + 1) mod NUM_SRCS.
  - rr_ptr holds its value when nothing issues.
- Response path, head = tag FIFO head:
  - src_rd_resp_val[i] = dst_rd_resp_val && !tag_empty && head==i.
  - dst_rd_resp_rdy = tag_empty ? 1 : src_rd_resp_rdy[head].
  - Pop the tag FIFO on dst_rd_resp_val && dst_rd_resp_rdy && !tag_empty.
- Error: dst_rd_resp_val while tag_empty drops the response (it is accepted) and sets resp_err.
  - resp_err stays set until the next reset.
- Full/empty boundaries:
  - When tag_full, no issue occurs, even if a pop happens in the same cycle.
  - Issue and pop may occur in the same cycle when not full; the count is unchanged.
- Counter: outstanding_cnt increments on issue only, decrements on pop only, and holds when both or neither occur.
- FIFO pointers are log2(MAX_OUTSTANDING) bits wide and wrap naturally; a separate count distinguishes full from empty.

## Timing
- Reset values (asynchronous):
  - Registered state: FIFO empty, rr_ptr=0, outstanding_cnt=0, resp_err=0.
  - Outputs: dst_rd_req_val=0, src_rd_req_rdy=0, src_rd_resp_val=0, dst_rd_resp_rdy=1.
- Latency: zero cycles added on both the request and response paths (combinational pass-through). Throughput is one issue and one return per cycle.
- Handshakes: valid/ready, with a transfer on the cycle where both are high.
  - Sources hold val and addr stable until rdy.
  - The block does not depend on the ready signal before asserting valid.
- Ordering: the memory must return responses in issue order; routing depends on this.
- Reset mid-operation clears all tags, discarding in-flight routing. The memory behind dst must be reset in the same domain; a stray post-reset response raises resp_err.

## Test plan
- Single read, NUM_SRCS=2, ARB_MODE=0:
  - Stimulus: src1 requests addr 0x2A; memory returns 0xDEAD one cycle later.
  - Required: dst_rd_req_addr=0x2A; src_rd_resp_val=2'b10 with data 0xDEAD; outstanding_cnt goes 0→1→0.
- Fixed-priority contention:
  - Stimulus: src0 and src1 both hold requests for 4 cycles with dst ready.
  - Required: src0 is granted in all 4 cycles and src1 is never granted.
- Round-robin fairness, NUM_SRCS=3, ARB_MODE=1:
  - Stimulus: all three sources request continuously.
  - Required: grant order is 0,1,2,0,1,2.
- Full FIFO, MAX_OUTSTANDING=4:
  - Stimulus: issue 4 reads with responses stalled.
  - Required: the 5th request sees rdy=0 and outstanding_cnt=4. Releasing one response allows the next issue on the following cycle, not the same cycle.
- Response backpressure with interleaving:
  - Stimulus: issue src0, src1, src0; hold src_rd_resp_rdy[0]=0 for 3 cycles.
  - Required: dst_rd_resp_rdy=0 for those cycles; responses are then delivered in order src0, src1, src0 with the data matching each request.
- Error and reset:
  - Stimulus: dst_rd_resp_val with no outstanding reads; later, assert rst_n=0 with 2 reads in flight.
  - Required: resp_err=1 (sticky). The reset asynchronously clears outstanding_cnt to 0, resp_err to 0 and FIFO state.
